// File: rtl/rv32im_pkg.sv
// RV32IM decode/execute shared definitions: opcodes, ALU/branch/immediate/writeback codes, ID/EX layout.
// No timing or flow control of its own; consumed by the decoder, ALU and top.
package rv32im_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // {mext, alt, funct3}
  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SLL    = 5'b00001,
    ALU_SLT    = 5'b00010,
    ALU_SLTU   = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_OR     = 5'b00110,
    ALU_AND    = 5'b00111,
    ALU_SUB    = 5'b01000,
    ALU_SRA    = 5'b01101,
    ALU_PASSB  = 5'b01111,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_NONE = 4'b0000,
    BR_BEQ  = 4'b1000,
    BR_BNE  = 4'b1001,
    BR_JUMP = 4'b1010,
    BR_BLT  = 4'b1100,
    BR_BGE  = 4'b1101,
    BR_BLTU = 4'b1110,
    BR_BGEU = 4'b1111
  } br_e;

  typedef enum logic [3:0] {
    IMM_I = 4'd0,
    IMM_S = 4'd1,
    IMM_B = 4'd2,
    IMM_U = 4'd3,
    IMM_J = 4'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_PC4  = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_ZERO = 2'd3
  } wb_sel_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        op1_pc;
    logic        op2_imm;
    br_e         branch;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    wb_sel_e     wb_sel;
    logic        reg_write_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
  } idex_t;

endpackage

// File: rtl/rv32im_alu.sv
// Combinational RV32IM ALU, single-cycle including multiply and divide.
// No flow control; result is a pure function of op, a and b.
module rv32im_alu
  import rv32im_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        mul_a_signed;
  logic        mul_b_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_signed;
  logic [31:0] r_signed;
  logic        div_zero;

  // One 64-bit multiplier serves all four multiplies; only the operand extension differs.
  assign mul_a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
  assign mul_b_signed = (op == ALU_MULH);
  assign a_ext        = {{32{mul_a_signed & a[31]}}, a};
  assign b_ext        = {{32{mul_b_signed & b[31]}}, b};
  assign prod         = a_ext * b_ext;

  // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0 naturally.
  assign a_mag    = a[31] ? (~a + 32'd1) : a;
  assign b_mag    = b[31] ? (~b + 32'd1) : b;
  assign q_mag    = a_mag / b_mag;
  assign r_mag    = a_mag % b_mag;
  assign q_signed = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_signed = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign div_zero = (b == 32'd0);

  always_comb begin
    y = '0;
    if (op[4]) begin
      case (op[2:0])
        3'b000:  y = prod[31:0];
        3'b001,
        3'b010,
        3'b011:  y = prod[63:32];
        3'b100:  y = div_zero ? 32'hFFFF_FFFF : q_signed;
        3'b101:  y = div_zero ? 32'hFFFF_FFFF : a / b;
        3'b110:  y = div_zero ? a : r_signed;
        default: y = div_zero ? a : a % b;
      endcase
    end else if (op == ALU_PASSB) begin
      y = b;
    end else begin
      case (op[2:0])
        3'b000:  y = op[3] ? (a - b) : (a + b);
        3'b001:  y = a << b[4:0];
        3'b010:  y = {31'd0, $signed(a) < $signed(b)};
        3'b011:  y = {31'd0, a < b};
        3'b100:  y = a ^ b;
        3'b101: begin
          if (op[3]) y = $signed(a) >>> b[4:0];
          else       y = a >> b[4:0];
        end
        3'b110:  y = a | b;
        default: y = a & b;
      endcase
    end
  end

endmodule

// File: rtl/rv32im_ctrl_decode.sv
// Combinational instruction decoder: INSTRUCTION -> control word and immediate type, zero latency.
// No flow control; unrecognised opcodes decode to an all-zero NOP.
module rv32im_ctrl_decode
  import rv32im_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output imm_sel_e    imm_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl    = CTRL_NOP;
    imm_sel = IMM_I;
    case (opcode)
      OPC_LUI: begin
        ctrl.alu_op       = ALU_PASSB;
        ctrl.op2_imm      = 1'b1;
        ctrl.wb_sel       = WB_ALU;
        ctrl.reg_write_en = 1'b1;
        imm_sel           = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.op1_pc       = 1'b1;
        ctrl.op2_imm      = 1'b1;
        ctrl.wb_sel       = WB_ALU;
        ctrl.reg_write_en = 1'b1;
        imm_sel           = IMM_U;
      end
      OPC_JAL: begin
        ctrl.op1_pc       = 1'b1;
        ctrl.op2_imm      = 1'b1;
        ctrl.branch       = BR_JUMP;
        ctrl.wb_sel       = WB_PC4;
        ctrl.reg_write_en = 1'b1;
        imm_sel           = IMM_J;
      end
      OPC_JALR: begin
        ctrl.op2_imm      = 1'b1;
        ctrl.branch       = BR_JUMP;
        ctrl.wb_sel       = WB_PC4;
        ctrl.reg_write_en = 1'b1;
        imm_sel           = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl.op1_pc  = 1'b1;
        ctrl.op2_imm = 1'b1;
        ctrl.branch  = br_e'({1'b1, funct3});
        imm_sel      = IMM_B;
      end
      OPC_LOAD: begin
        ctrl.op2_imm      = 1'b1;
        ctrl.mem_read     = {1'b1, funct3};
        ctrl.wb_sel       = WB_MEM;
        ctrl.reg_write_en = 1'b1;
        imm_sel           = IMM_I;
      end
      OPC_STORE: begin
        ctrl.op2_imm   = 1'b1;
        ctrl.mem_write = {1'b1, funct3[1:0]};
        imm_sel        = IMM_S;
      end
      OPC_OP_IMM: begin
        // Only the shift-right immediates carry an alt bit; elsewhere funct7 is immediate data.
        ctrl.alu_op       = alu_op_e'({1'b0, (funct3 == 3'b101) & funct7[5], funct3});
        ctrl.op2_imm      = 1'b1;
        ctrl.wb_sel       = WB_ALU;
        ctrl.reg_write_en = 1'b1;
        imm_sel           = IMM_I;
      end
      OPC_OP: begin
        ctrl.alu_op       = alu_op_e'({funct7 == 7'b0000001, funct7[5], funct3});
        ctrl.wb_sel       = WB_ALU;
        ctrl.reg_write_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32im_decode_execute.sv
// RV32IM decode + ID/EX register + execute; EX outputs valid one edge after the instruction is presented.
// HOLD freezes the ID/EX register (RESET wins over HOLD); all EX outputs are combinational from it.
module rv32im_decode_execute
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            HOLD,
  input  logic [XLEN-1:0] INSTRUCTION,
  input  logic [XLEN-1:0] PC_IN,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [XLEN-1:0] IMM_IN,
  output logic [3:0]      IMM_SEL,
  output logic [XLEN-1:0] ALU_OUT,
  output logic            BRANCH_TAKEN,
  output logic [XLEN-1:0] DATA2_EX,
  output logic [3:0]      MEM_READ,
  output logic [2:0]      MEM_WRITE,
  output logic [1:0]      REG_WRITE_SEL,
  output logic            REG_WRITE_EN,
  output logic [XLEN-1:0] PC_EX
);

  ctrl_t       dec_ctrl;
  imm_sel_e    dec_imm_sel;
  idex_t       idex;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_y;
  logic        is_jalr;

  rv32im_ctrl_decode u_decode (
    .instr   (INSTRUCTION),
    .ctrl    (dec_ctrl),
    .imm_sel (dec_imm_sel)
  );

  assign IMM_SEL = dec_imm_sel;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idex <= '0;
    end else if (!HOLD) begin
      idex <= '{ctrl: dec_ctrl, pc: PC_IN, data1: DATA1, data2: DATA2, imm: IMM_IN};
    end
  end

  assign op_a = idex.ctrl.op1_pc  ? idex.pc  : idex.data1;
  assign op_b = idex.ctrl.op2_imm ? idex.imm : idex.data2;

  rv32im_alu u_alu (
    .op (idex.ctrl.alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  // JALR is the only jump whose base is rs1; its target LSB must be forced to zero.
  assign is_jalr = (idex.ctrl.branch == BR_JUMP) && !idex.ctrl.op1_pc;
  assign ALU_OUT = is_jalr ? {alu_y[31:1], 1'b0} : alu_y;

  always_comb begin
    BRANCH_TAKEN = 1'b0;
    case (idex.ctrl.branch)
      BR_BEQ:  BRANCH_TAKEN = (idex.data1 == idex.data2);
      BR_BNE:  BRANCH_TAKEN = (idex.data1 != idex.data2);
      BR_BLT:  BRANCH_TAKEN = ($signed(idex.data1) <  $signed(idex.data2));
      BR_BGE:  BRANCH_TAKEN = ($signed(idex.data1) >= $signed(idex.data2));
      BR_BLTU: BRANCH_TAKEN = (idex.data1 <  idex.data2);
      BR_BGEU: BRANCH_TAKEN = (idex.data1 >= idex.data2);
      BR_JUMP: BRANCH_TAKEN = 1'b1;
      default: BRANCH_TAKEN = 1'b0;
    endcase
  end

  assign DATA2_EX      = idex.data2;
  assign MEM_READ      = idex.ctrl.mem_read;
  assign MEM_WRITE     = idex.ctrl.mem_write;
  assign REG_WRITE_SEL = idex.ctrl.wb_sel;
  assign REG_WRITE_EN  = idex.ctrl.reg_write_en;
  assign PC_EX         = idex.pc;

endmodule

// File: tb/tb_rv32im_decode_execute.sv
// Directed + random bench for rv32im_decode_execute against an arithmetic reference model.
module tb_rv32im_decode_execute;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        HOLD = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic [31:0] PC_IN = '0;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic [31:0] IMM_IN = '0;
  logic [3:0]  IMM_SEL;
  logic [31:0] ALU_OUT;
  logic        BRANCH_TAKEN;
  logic [31:0] DATA2_EX;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [1:0]  REG_WRITE_SEL;
  logic        REG_WRITE_EN;
  logic [31:0] PC_EX;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] alu;
    logic        taken;
    logic [31:0] data2;
    logic [3:0]  mr;
    logic [2:0]  mw;
    logic [1:0]  rws;
    logic        rwe;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q;

  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [6:0] bad_opc [4] = '{7'h0F, 7'h73, 7'h7F, 7'h00};

  rv32im_decode_execute #(.XLEN(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .HOLD          (HOLD),
    .INSTRUCTION   (INSTRUCTION),
    .PC_IN         (PC_IN),
    .DATA1         (DATA1),
    .DATA2         (DATA2),
    .IMM_IN        (IMM_IN),
    .IMM_SEL       (IMM_SEL),
    .ALU_OUT       (ALU_OUT),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .DATA2_EX      (DATA2_EX),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .REG_WRITE_SEL (REG_WRITE_SEL),
    .REG_WRITE_EN  (REG_WRITE_EN),
    .PC_EX         (PC_EX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{alu: 0, taken: 0, data2: 0, mr: 0, mw: 0, rws: 0, rwe: 0, pc: 0};
    return e;
  endfunction

  function automatic logic [3:0] ref_imm_sel(input logic [31:0] ins);
    case (ins[6:0])
      7'h37, 7'h17: return 4'd3;
      7'h6F:        return 4'd4;
      7'h63:        return 4'd2;
      7'h23:        return 4'd1;
      default:      return 4'd0;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int ia = a;
    int ib = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return 1'b1;
      3'd4: return ia < ib;
      3'd5: return ia >= ib;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_base(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
    int ia = a;
    int ib = b;
    int sr;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (ia < ib) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (!alt) return a >> b[4:0];
        sr = ia >>> b[4:0];
        return sr;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] ref_mext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    int ia = a;
    int ib = b;
    int r;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        r = ia / ib;
        return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        r = ia % ib;
        return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] imm);
    exp_t e = zero_exp();
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    e.data2 = d2;
    e.pc    = pc;
    case (ins[6:0])
      7'h37: begin e.alu = imm;      e.rws = 1; e.rwe = 1; end
      7'h17: begin e.alu = pc + imm; e.rws = 1; e.rwe = 1; end
      7'h6F: begin e.alu = pc + imm; e.taken = 1; e.rwe = 1; end
      7'h67: begin e.alu = (d1 + imm) & ~32'd1; e.taken = 1; e.rwe = 1; end
      7'h63: begin e.alu = pc + imm; e.taken = ref_branch(f3, d1, d2); end
      7'h03: begin e.alu = d1 + imm; e.mr = {1'b1, f3}; e.rws = 2; e.rwe = 1; end
      7'h23: begin e.alu = d1 + imm; e.mw = {1'b1, f3[1:0]}; end
      7'h13: begin
        e.alu = ref_base(f3, (f3 == 3'd5) && f7[5], d1, imm);
        e.rws = 1; e.rwe = 1;
      end
      7'h33: begin
        e.alu = (f7 == 7'd1) ? ref_mext(f3, d1, d2) : ref_base(f3, f7[5], d1, d2);
        e.rws = 1; e.rwe = 1;
      end
      default: e.alu = d1 + d2;
    endcase
    return e;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".alu"},   ALU_OUT,                exp_q.alu);
    chk({tag, ".taken"}, {31'd0, BRANCH_TAKEN},  {31'd0, exp_q.taken});
    chk({tag, ".data2"}, DATA2_EX,               exp_q.data2);
    chk({tag, ".mr"},    {28'd0, MEM_READ},      {28'd0, exp_q.mr});
    chk({tag, ".mw"},    {29'd0, MEM_WRITE},     {29'd0, exp_q.mw});
    chk({tag, ".rwe"},   {31'd0, REG_WRITE_EN},  {31'd0, exp_q.rwe});
    if (exp_q.rwe) chk({tag, ".rws"}, {30'd0, REG_WRITE_SEL}, {30'd0, exp_q.rws});
    chk({tag, ".pc"},    PC_EX,                  exp_q.pc);
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                      input logic hold, input logic rst);
    INSTRUCTION = ins; PC_IN = pc; DATA1 = d1; DATA2 = d2; IMM_IN = imm;
    HOLD = hold; RESET = rst;
    #1;
    chk({tag, ".imm_sel"}, {28'd0, IMM_SEL}, {28'd0, ref_imm_sel(ins)});
    @(posedge CLK);
    if (rst)        exp_q = zero_exp();
    else if (!hold) exp_q = model(ins, pc, d1, d2, imm);
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 16));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    logic [24:0] body = r[31:7];
    logic [2:0]  f3;
    logic [6:0]  f7;
    case ($urandom_range(0, 9))
      0: return {body, 7'h37};
      1: return {body, 7'h17};
      2: return {body, 7'h6F};
      3: return {body[24:8], 3'd0, body[4:0], 7'h67};
      4: return {body[24:8], br_f3[$urandom_range(0, 5)], body[4:0], 7'h63};
      5: return {body[24:8], ld_f3[$urandom_range(0, 4)], body[4:0], 7'h03};
      6: begin f3 = 3'($urandom_range(0, 2)); return {body[24:8], f3, body[4:0], 7'h23}; end
      7: begin
        f3 = 3'($urandom_range(0, 7));
        f7 = body[24:18];
        if (f3 == 3'd1) f7 = 7'h00;
        if (f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return {f7, body[17:8], f3, body[4:0], 7'h13};
      end
      8: begin
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0: f7 = 7'h00;
          1: f7 = 7'h01;
          default: begin f7 = 7'h20; f3 = $urandom_range(0, 1) ? 3'd5 : 3'd0; end
        endcase
        return {f7, body[17:8], f3, body[4:0], 7'h33};
      end
      default: return {body, bad_opc[$urandom_range(0, 3)]};
    endcase
  endfunction

  initial begin
    exp_q = zero_exp();

    step("reset", 32'h0020_81B3, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1);
    chk("reset.alu_zero", ALU_OUT, 32'd0);

    step("add", 32'h0020_81B3, 32'h40, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0);
    chk("add.const", ALU_OUT, 32'd12);
    chk("add.rwe", {31'd0, REG_WRITE_EN}, 32'd1);
    chk("add.rws", {30'd0, REG_WRITE_SEL}, 32'd1);

    step("sub", 32'h4020_81B3, 32'h44, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0);
    chk("sub.const", ALU_OUT, 32'hFFFF_FFFE);
    step("sra", 32'h4020_D1B3, 32'h48, 32'h8000_0000, 32'd4, 32'h0, 1'b0, 1'b0);
    chk("sra.const", ALU_OUT, 32'hF800_0000);
    step("mulhu", 32'h0220_B1B3, 32'h4C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    chk("mulhu.const", ALU_OUT, 32'hFFFF_FFFE);
    step("div0", 32'h0220_C1B3, 32'h50, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0);
    chk("div0.const", ALU_OUT, 32'hFFFF_FFFF);
    step("removf", 32'h0220_E1B3, 32'h54, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    chk("removf.const", ALU_OUT, 32'd0);
    step("divu", 32'h0220_D1B3, 32'h58, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0);
    chk("divu.const", ALU_OUT, 32'd14);

    step("blt", 32'h0020_C063, 32'h5C, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0, 1'b0);
    chk("blt.const", {31'd0, BRANCH_TAKEN}, 32'd1);
    step("bltu", 32'h0020_E063, 32'h60, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0, 1'b0);
    chk("bltu.const", {31'd0, BRANCH_TAKEN}, 32'd0);
    step("beq", 32'h0020_8063, 32'h100, 32'd9, 32'd9, 32'h20, 1'b0, 1'b0);
    chk("beq.taken", {31'd0, BRANCH_TAKEN}, 32'd1);
    chk("beq.target", ALU_OUT, 32'h120);

    step("jalr", 32'h0000_80E7, 32'h200, 32'h1001, 32'd0, 32'd2, 1'b0, 1'b0);
    chk("jalr.target", ALU_OUT, 32'h1002);
    chk("jalr.taken", {31'd0, BRANCH_TAKEN}, 32'd1);
    chk("jalr.rws", {30'd0, REG_WRITE_SEL}, 32'd0);

    step("lw", 32'h0000_A083, 32'h204, 32'h200, 32'd0, 32'd4, 1'b0, 1'b0);
    chk("lw.addr", ALU_OUT, 32'h204);
    chk("lw.mr", {28'd0, MEM_READ}, 32'hA);

    step("sb", 32'h0020_8023, 32'h208, 32'h300, 32'hAB, 32'd1, 1'b0, 1'b0);
    chk("sb.mw", {29'd0, MEM_WRITE}, 32'h4);
    chk("sb.rwe", {31'd0, REG_WRITE_EN}, 32'd0);

    step("hold", 32'h0020_81B3, 32'h999, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0);
    chk("hold.mw", {29'd0, MEM_WRITE}, 32'h4);
    chk("hold.alu", ALU_OUT, 32'h301);

    step("nop", 32'h0000_007F, 32'h20C, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("nop.rwe", {31'd0, REG_WRITE_EN}, 32'd0);
    chk("nop.taken", {31'd0, BRANCH_TAKEN}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      step("rand", rnd_instr(), $urandom, rnd_val(), rnd_val(), rnd_val(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32im_decode_execute.md
Name: rv32im_decode_execute

Overview:
- RV32IM decode plus execute slice of the 5-stage pipeline, sitting between the fetch/register-read stage and the memory stage.
- A combinational control decoder turns INSTRUCTION into control signals. An ID/EX pipeline register latches the controls and operands.
- A combinational 32-bit ALU (RV32I + M extension) and a branch comparator act on the latched values.
- Outputs feed the PC-select mux (ALU_OUT, BRANCH_TAKEN) and the EX/MEM register.

Parameters:
- XLEN, 32, datapath width (only 32 supported).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- HOLD  in  1  when 1, the ID/EX register keeps its value (cache busy-wait).
- INSTRUCTION  in  32  instruction in decode.
- PC_IN  in  32  PC of the decoded instruction.
- DATA1  in  32  rs1 value.
- DATA2  in  32  rs2 value.
- IMM_IN  in  32  immediate from the external immediate generator.
- IMM_SEL  out  4  combinational immediate type: 0=I, 1=S, 2=B, 3=U, 4=J.
- ALU_OUT  out  32  combinational ALU result of the latched instruction.
- BRANCH_TAKEN  out  1  combinational take-branch/jump flag.
- DATA2_EX  out  32  latched rs2, used as store data.
- MEM_READ  out  4  latched load control.
- MEM_WRITE  out  3  latched store control.
- REG_WRITE_SEL  out  2  latched writeback select: 0=PC+4, 1=ALU, 2=memory, 3=zero.
- REG_WRITE_EN  out  1  latched register-write enable.
- PC_EX  out  32  latched PC.

Behaviour:
- Latency: an instruction present before rising edge n drives all EX outputs after edge n, combinationally from the ID/EX register.
- Priority at each rising edge: RESET > HOLD > load.
  - RESET=1: the register clears to a NOP. All controls are 0, BRANCH_TAKEN=0, data and PC fields are 0, so ALU_OUT=0.
  - HOLD=1 without RESET: the register is unchanged.
  - Otherwise it loads the decoded controls, PC_IN, DATA1, DATA2 and IMM_IN.
- ALU select code (5 bits):
  - Bit 4 = M extension; bit 3 = alt (SUB/SRA); bits[2:0] = funct3.
  - 5'b01111 = pass operand B (used by LUI).
- Operand selects:
  - op1: 0=DATA1, 1=PC.
  - op2: 0=DATA2, 1=IMM.
- Decode by opcode:
  - LUI 0110111: ALU pass-B, op2=IMM, IMM_SEL=U, write ALU.
  - AUIPC 0010111: ADD, op1=PC, op2=IMM, IMM_SEL=U, write ALU.
  - JAL 1101111: ADD PC+IMM, IMM_SEL=J, branch=JUMP, write PC+4.
  - JALR 1100111: ADD rs1+IMM, IMM_SEL=I, branch=JUMP, write PC+4. The target's LSB is cleared on ALU_OUT.
  - BRANCH 1100011: ADD PC+IMM, IMM_SEL=B, branch={1,funct3}, no write.
  - LOAD 0000011: ADD rs1+IMM, IMM_SEL=I, MEM_READ={1,funct3}, write memory.
  - STORE 0100011: ADD rs1+IMM, IMM_SEL=S, MEM_WRITE={1,funct3[1:0]}, no write.
  - OP-IMM 0010011: alu={0, (funct3==101)&funct7[5], funct3}, op2=IMM, IMM_SEL=I, write ALU.
  - OP 0110011: alu={funct7==0000001, funct7[5], funct3}, write ALU.
  - Any other opcode: NOP; all enables 0, IMM_SEL=0.
- Branch code (4 bits):
  - 0xxx = none.
  - 1000 BEQ, 1001 BNE, 1100 BLT, 1101 BGE, 1110 BLTU, 1111 BGEU.
  - 1010 = unconditional JUMP.
  - 1011 = none.
  - Comparisons use latched DATA1 vs DATA2; signed for BLT/BGE, unsigned for BLTU/BGEU.
- ALU results are 32 bits:
  - ADD/SUB wrap modulo 2^32.
  - Shifts use B[4:0]; SRA is arithmetic.
  - SLT and SLTU return 0 or 1.
  - MUL returns the low 32 bits of the product.
  - MULH (s×s), MULHSU (s×u) and MULHU (u×u) return the high 32 bits of the 64-bit product.
  - DIV/REM round toward zero.
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return the dividend.
  - Overflow 0x80000000/−1: DIV returns 0x80000000, REM returns 0.
- The ALU is fully combinational with no multi-cycle operations.

Decomposition:
- Package rv32im_pkg holds:
  - opcode constants;
  - ALU codes (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, MUL..REMU);
  - branch codes;
  - IMM_SEL codes;
  - REG_WRITE_SEL codes.
- Sub-modules: rv32im_ctrl_decode (combinational decoder) and rv32im_alu (combinational ALU). The branch comparator and the ID/EX register stay in the top module.

Test Plan:
- RESET=1 for one edge, then ADD instruction 0x002081B3 with DATA1=5, DATA2=7, released with HOLD=0 -> after the reset edge all outputs are 0; after the next edge ALU_OUT=12, REG_WRITE_EN=1, REG_WRITE_SEL=1.
- SUB 0x402081B3 with DATA1=3, DATA2=5 -> ALU_OUT=0xFFFFFFFE. SRA (OP, funct3 101, funct7 0100000) with DATA1=0x80000000, DATA2=4 -> 0xF8000000.
- M extension (funct7 0000001):
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - DIV 7/0 -> 0xFFFFFFFF.
  - REM 0x80000000 % 0xFFFFFFFF -> 0.
  - DIVU 100/7 -> 14.
- Branches:
  - BLT with DATA1=0xFFFFFFFF, DATA2=1 -> BRANCH_TAKEN=1.
  - BLTU with the same operands -> 0.
  - BEQ with equal operands, PC_IN=0x100, IMM_IN=0x20 -> BRANCH_TAKEN=1, ALU_OUT=0x120.
- JALR with DATA1=0x1001, IMM_IN=2 -> ALU_OUT=0x1002, BRANCH_TAKEN=1, REG_WRITE_SEL=0.
- LW with DATA1=0x200, IMM_IN=4 -> ALU_OUT=0x204, MEM_READ=4'b1010.
- SB -> MEM_WRITE=3'b100, REG_WRITE_EN=0.
- Hold an instruction with HOLD=1 while INSTRUCTION changes -> outputs are unchanged.
- Unknown opcode 0x0000007F -> NOP.
